// File: rtl/riscv_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// The data width (XLEN) is fixed here so that the struct, the interface
// and the FIFO all agree on it.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the writeback-port signals.
// The "master" modport is the pipeline/long-latency side that drives
// requests. The "slave" modport is the arbiter.
interface wb_port_arbiter_if;
    import riscv_pkg::*;

    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [XLEN-1:0]       ResultW;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  lat_valid;
    logic [REG_ADDR_W-1:0] lat_rd;
    logic [XLEN-1:0]       lat_data;
    logic                  lat_ready;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wd;
    logic [31:0]           busy_vec;
    logic                  stall_req;

    modport master (
        output RegWriteW, RdW, ResultW, issue_valid, issue_rd,
               lat_valid, lat_rd, lat_data,
        input  lat_ready, rf_we, rf_rd, rf_wd, busy_vec, stall_req
    );

    modport slave (
        input  RegWriteW, RdW, ResultW, issue_valid, issue_rd,
               lat_valid, lat_rd, lat_data,
        output lat_ready, rf_we, rf_rd, rf_wd, busy_vec, stall_req
    );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO that holds long-latency results until the
// register-file write port is free.
// The pointers carry one extra bit so that full and empty can be told apart.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
)
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  wb_req_t pushData_i,
    input  logic    pop_i,
    output wb_req_t head_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int AW = $clog2(DEPTH);

    wb_req_t        mem_q [DEPTH];
    logic [AW:0]    wrPtr_q, wrPtr_d;
    logic [AW:0]    rdPtr_q, rdPtr_d;

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                     (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign head_o  = mem_q[rdPtr_q[AW-1:0]];

    // Advance the pointers. Requests against a full or empty FIFO are ignored.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (push_i && !full_o) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop_i && !empty_o) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
    end

    // Pointer registers. Reset empties the FIFO and discards its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    // Storage needs no reset because empty pointers mask stale entries.
    always_ff @(posedge clk) begin
        if (rst && push_i && !full_o) begin
            mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// In-order W-stage writes always win. Out-of-order long-latency results
// queue in wb_fifo and drain on free cycles. A busy vector tracks the
// destinations that are still in flight. A starvation counter asks for a
// pipeline bubble when the queue head has been blocked too long.
// Optional feature: define WB_ARB_BYPASS_EN to let a long-latency result go
// straight to the register file when the port and the queue are both idle.
module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    wb_req_t               fifoHead;
    wb_req_t               pushData;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic                  fifoPush;
    logic                  fifoPop;
    logic                  pipeValid;
    logic                  latReady;
    logic                  bypassHit;
    logic                  bypassWrite;

    logic                  rfWe;
    logic [REG_ADDR_W-1:0] rfRd;
    logic [XLEN-1:0]       rfWd;
    logic [REG_ADDR_W-1:0] lastRd_q;
    logic [XLEN-1:0]       lastWd_q;

    logic [31:0]           busy_q, busy_d;
    logic [31:0]           setVec, clrVec;
    logic [CW-1:0]         starveCnt_q, starveCnt_d;
    logic                  stall_q, stall_d;

    // A W-stage write to x0 is discarded, so it never claims the port.
    assign pipeValid = bus.RegWriteW && (bus.RdW != '0);

    // Acceptance uses registered occupancy only. A full queue stays closed
    // even when it pops in the same cycle.
    assign latReady  = rst && !fifoFull;

`ifdef WB_ARB_BYPASS_EN
    assign bypassHit = rst && !pipeValid && fifoEmpty && bus.lat_valid;
`else
    assign bypassHit = 1'b0;
`endif

    assign bypassWrite = bypassHit && (bus.lat_rd != '0);

    // Results aimed at x0 are accepted but never stored.
    assign fifoPush  = bus.lat_valid && latReady && (bus.lat_rd != '0) && !bypassHit;
    assign fifoPop   = rst && !pipeValid && !fifoEmpty;
    assign pushData  = '{rd: bus.lat_rd, data: bus.lat_data};

    wb_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifoPush),
        .pushData_i (pushData),
        .pop_i      (fifoPop),
        .head_o     (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty)
    );

    // Port mux: pipeline first, then queue head, then bypass.
    // When idle, the address and data buses repeat the last write.
    always_comb begin
        rfWe = 1'b0;
        rfRd = lastRd_q;
        rfWd = lastWd_q;
        if (!rst) begin
            rfRd = '0;
            rfWd = '0;
        end else if (pipeValid) begin
            rfWe = 1'b1;
            rfRd = bus.RdW;
            rfWd = bus.ResultW;
        end else if (!fifoEmpty) begin
            rfWe = 1'b1;
            rfRd = fifoHead.rd;
            rfWd = fifoHead.data;
        end else if (bypassWrite) begin
            rfWe = 1'b1;
            rfRd = bus.lat_rd;
            rfWd = bus.lat_data;
        end
    end

    // Remember the last driven address and data for the idle hold value.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lastRd_q <= '0;
            lastWd_q <= '0;
        end else if (rfWe) begin
            lastRd_q <= rfRd;
            lastWd_q <= rfWd;
        end
    end

    // Scoreboard update. Issue sets a bit and a long-latency write clears it.
    // The set is applied last, so it wins a same-register collision.
    always_comb begin
        setVec = '0;
        clrVec = '0;
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            setVec[bus.issue_rd] = 1'b1;
        end
        if (fifoPop || bypassWrite) begin
            clrVec[rfRd] = 1'b1;
        end
        busy_d = (busy_q & ~clrVec) | setVec;
    end

    // Starvation counter. It counts cycles in which a queued result lost the
    // port and saturates at the limit. The stall request is the registered
    // "at limit" flag, so it holds until a pop clears the count.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fifoEmpty || fifoPop) begin
            starveCnt_d = '0;
        end else if (starveCnt_q != CW'(STARVE_LIMIT)) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
        stall_d = (starveCnt_d == CW'(STARVE_LIMIT));
    end

    // State registers for the scoreboard and the starvation logic.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q      <= '0;
            starveCnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            busy_q      <= busy_d;
            starveCnt_q <= starveCnt_d;
            stall_q     <= stall_d;
        end
    end

    assign bus.lat_ready = latReady;
    assign bus.rf_we     = rfWe;
    assign bus.rf_rd     = rfRd;
    assign bus.rf_wd     = rfWd;
    assign bus.busy_vec  = busy_q;
    assign bus.stall_req = stall_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Testbench for wb_port_arbiter.
// A reference model built from queues predicts every register-file write and
// pushes it into a scoreboard. A monitor running on the falling edge pops the
// scoreboard on each rf_we and also compares the status outputs.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk;
    logic rst;

    wb_port_arbiter_if bus();

    wb_port_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    logic [36:0] expWrites [$];
    logic [36:0] modelQ    [$];
    logic [31:0] modelBusy;
    int          modelBlocked;
    bit          modelStall;
    logic [4:0]  modelLastRd;
    logic [31:0] modelLastWd;

    // Expectations for the cycle currently being driven.
    bit          running;
    bit          inReset;
    bit          expLatReady;
    logic [31:0] expBusy;
    bit          expStall;
    logic [4:0]  expHoldRd;
    logic [31:0] expHoldWd;

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model and wait for the edge.
    task automatic applyStimulus(input bit regW, input logic [4:0] rdW,
                                 input logic [31:0] resW, input bit issV,
                                 input logic [4:0] issRd, input bit latV,
                                 input logic [4:0] latRd, input logic [31:0] latD,
                                 output bit accepted);
        logic [36:0] head;
        bit wasEmpty;
        bit popped;
        bit bypassed;
        bus.RegWriteW   = regW;
        bus.RdW         = rdW;
        bus.ResultW     = resW;
        bus.issue_valid = issV;
        bus.issue_rd    = issRd;
        bus.lat_valid   = latV;
        bus.lat_rd      = latRd;
        bus.lat_data    = latD;

        expLatReady = (modelQ.size() < DEPTH);
        expBusy     = modelBusy;
        expStall    = modelStall;
        expHoldRd   = modelLastRd;
        expHoldWd   = modelLastWd;

        wasEmpty = (modelQ.size() == 0);
        popped   = 0;
        bypassed = 0;
        if (regW && rdW != 0) begin
            expWrites.push_back({rdW, resW});
            modelLastRd = rdW;
            modelLastWd = resW;
        end else if (!wasEmpty) begin
            head = modelQ.pop_front();
            expWrites.push_back(head);
            modelBusy[head[36:32]] = 1'b0;
            modelLastRd = head[36:32];
            modelLastWd = head[31:0];
            popped = 1;
        end
`ifdef WB_ARB_BYPASS_EN
        else if (latV) begin
            bypassed = 1;
            if (latRd != 0) begin
                expWrites.push_back({latRd, latD});
                modelBusy[latRd] = 1'b0;
                modelLastRd = latRd;
                modelLastWd = latD;
            end
        end
`endif
        accepted = latV && expLatReady;
        if (accepted && latRd != 0 && !bypassed) begin
            modelQ.push_back({latRd, latD});
        end
        if (issV && issRd != 0) begin
            modelBusy[issRd] = 1'b1;
        end
        if (wasEmpty || popped) begin
            modelBlocked = 0;
        end else if (modelBlocked < STARVE_LIMIT) begin
            modelBlocked++;
        end
        modelStall = (modelBlocked == STARVE_LIMIT);

        @(posedge clk);
        #1;
    endtask

    task automatic holdReset(input int cycles);
        rst             = 1'b0;
        inReset         = 1'b1;
        bus.RegWriteW   = 1'b0;
        bus.RdW         = '0;
        bus.ResultW     = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.lat_valid   = 1'b0;
        bus.lat_rd      = '0;
        bus.lat_data    = '0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
        modelQ.delete();
        modelBusy    = '0;
        modelBlocked = 0;
        modelStall   = 0;
        modelLastRd  = '0;
        modelLastWd  = '0;
        rst     = 1'b1;
        inReset = 1'b0;
    endtask

    task automatic idle(input int cycles);
        bit acc;
        repeat (cycles) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, acc);
    endtask

    // Monitor: pops the scoreboard on each write and checks status outputs.
    initial begin
        forever begin
            @(negedge clk);
            if (running) begin
                if (inReset) begin
                    checkOutput("resetWe", 64'(bus.rf_we), 64'd0);
                    checkOutput("resetLatReady", 64'(bus.lat_ready), 64'd0);
                    checkOutput("resetRdWd", 64'({bus.rf_rd, bus.rf_wd}), 64'd0);
                end else begin
                    if (bus.rf_we) begin
                        if (expWrites.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL unexpectedWrite actual=%0h required=none at %0t",
                                     {bus.rf_rd, bus.rf_wd}, $time);
                        end else begin
                            checkOutput("writeRdWd", 64'({bus.rf_rd, bus.rf_wd}),
                                        64'(expWrites.pop_front()));
                        end
                    end else begin
                        checkOutput("idleHold", 64'({bus.rf_rd, bus.rf_wd}),
                                    64'({expHoldRd, expHoldWd}));
                    end
                    checkOutput("latReady", 64'(bus.lat_ready), 64'(expLatReady));
                    checkOutput("busyVec", 64'(bus.busy_vec), 64'(expBusy));
                    checkOutput("stallReq", 64'(bus.stall_req), 64'(expStall));
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        bit acc;
        running = 1'b1;
        holdReset(2);
        idle(2);

        // Issue x5, then the result arrives two cycles later on an idle port.
        applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, acc);
        idle(1);
        applyStimulus(0, 0, 0, 0, 0, 1, 5, 32'hDDDDDDDD, acc);
        idle(3);

        // Collision: the pipeline write to x3 goes first and x7 follows.
        applyStimulus(1, 3, 32'hAAAAAAAA, 1, 7, 1, 7, 32'h11, acc);
        idle(3);

        // Starvation: one queued entry blocked by continuous pipeline writes.
        applyStimulus(1, 1, 32'h100, 1, 9, 1, 9, 32'h99, acc);
        for (int k = 0; k < 6; k++) applyStimulus(1, 5'(k + 2), 32'(k), 0, 0, 0, 0, 0, acc);
        idle(3);

        // Fill the queue, hold off a third result and preserve the order.
        applyStimulus(1, 1, 32'h200, 0, 0, 1, 10, 32'hA0, acc);
        applyStimulus(1, 2, 32'h201, 0, 0, 1, 11, 32'hA1, acc);
        acc = 0;
        for (int k = 0; k < 20 && !acc; k++) begin
            applyStimulus(k < 2, 5'd4, 32'(k), 0, 0, 1, 12, 32'hA2, acc);
        end
        idle(4);

        // x0 pipeline write lets the queue head through; a result for x0 is dropped.
        applyStimulus(1, 6, 32'h300, 1, 9, 1, 9, 32'h909, acc);
        applyStimulus(1, 0, 32'h301, 0, 0, 0, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'hBAD, acc);
        idle(3);

        // Reset with results still queued discards them.
        applyStimulus(1, 1, 32'h400, 1, 13, 1, 13, 32'hC0, acc);
        applyStimulus(1, 2, 32'h401, 1, 14, 1, 14, 32'hC1, acc);
        holdReset(2);
        idle(3);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), 5'($urandom), $urandom,
                          1'($urandom_range(0, 3) == 0), 5'($urandom),
                          1'($urandom_range(0, 2) == 0), 5'($urandom), $urandom, acc);
        end
        idle(8);
        running = 1'b0;

        checkOutput("scoreboardDrained", 64'(expWrites.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Arbitrates the single register-file write port between two sources:
- the in-order W-stage result (ResultW/RdW from the writeback mux);
- results from long-latency units (multi-cycle MUL/DIV) that finish out of order.
Long-latency results wait in a small FIFO. A pending-destination scoreboard tells the hazard unit which registers are still in flight. A starvation counter can request a pipeline bubble so that queued results drain.

Parameters:
XLEN, 32, data width
DEPTH, 2, long-latency result FIFO entries (power of two, >=2)
STARVE_LIMIT, 4, consecutive cycles the FIFO head may be blocked before stall_req

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-low reset
RegWriteW  in  1  W-stage write enable
RdW  in  5  W-stage destination register
ResultW  in  XLEN  W-stage result (writeback mux output)
issue_valid  in  1  long-latency op issued this cycle
issue_rd  in  5  destination of issued op
lat_valid  in  1  long-latency result available
lat_rd  in  5  destination of long-latency result
lat_data  in  XLEN  long-latency result
lat_ready  out  1  arbiter accepts lat result this cycle
rf_we  out  1  register-file write enable
rf_rd  out  5  register-file write address
rf_wd  out  XLEN  register-file write data
busy_vec  out  32  bit i set = xi has a pending long-latency result
stall_req  out  1  request pipeline bubble in W next cycle

Behaviour:
- Reset (rst=0 at posedge):
  - FIFO emptied; busy_vec=0; starve counter=0; stall_req=0.
  - During reset, rf_we=0, lat_ready=0, rf_rd=0 and rf_wd=0.
  - Reset mid-operation discards queued results without writing them.
- Pipeline write is valid when RegWriteW=1 and RdW!=0. Writes to x0 from either source are never issued (rf_we=0).
- Priority each cycle (combinational outputs):
  - A valid pipeline write takes the port: rf_we=1, rf_rd=RdW, rf_wd=ResultW.
  - Otherwise, if the FIFO is non-empty, the FIFO head is popped and written.
  - Otherwise rf_we=0, and rf_rd/rf_wd hold their last driven value.
- Push rules:
  - lat_ready = !full, based on registered occupancy. A full FIFO does not accept a result even if it pops in the same cycle.
  - Push occurs on lat_valid && lat_ready.
  - lat_rd=0 is accepted but not stored.
- Latency: a pushed result is written no earlier than the next cycle (without bypass).
- busy_vec:
  - Set bit issue_rd when issue_valid && issue_rd!=0.
  - Clear bit rf_rd on a FIFO-sourced write.
  - Same-register set and clear in one cycle: set wins.
  - Pipeline writes never change busy_vec.
- Starvation counter:
  - Increments when the FIFO is non-empty and the pipeline wins the port.
  - Clears on any pop, or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - stall_req = (count==STARVE_LIMIT), registered; held until the next pop.
  - If RegWriteW is still asserted while stall_req=1, the pipeline still wins. No pipeline data is lost.
- Occupancy pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

Optional Feature:
Macro WB_ARB_BYPASS_EN.
- Defined: when the FIFO is empty, no valid pipeline write exists and lat_valid=1, lat data is written directly the same cycle (rf_we=1, rf_rd=lat_rd) and not pushed. busy_vec is cleared as for a FIFO write.
- Undefined: all long-latency results pass through the FIFO, with minimum one-cycle latency.

Decomposition:
- Package riscv_pkg holds:
  - constants XLEN and REG_ADDR_W=5;
  - typedef wb_req_t {rd[4:0], data[XLEN-1:0]}.
- Sub-module wb_fifo: a synchronous FIFO of wb_req_t with push/pop/full/empty, same clk/rst.
- Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
1. Reset held 2 cycles, then released with no traffic -> rf_we=0, busy_vec=0, lat_ready=1, stall_req=0.
2. issue x5; two cycles later lat x5=0xDDDDDDDD with RegWriteW=0 -> next cycle rf_we=1, rf_rd=5, rf_wd=0xDDDDDDDD; busy_vec[5] 1 then 0.
3. lat x7=0x11 in the same cycle as pipeline RdW=3, ResultW=0xAAAAAAAA -> x3 written first; x7 written the following free cycle.
4. Pipeline writes every cycle while the FIFO holds one entry -> stall_req=1 after 4 blocked cycles. Pipeline bubble (RegWriteW=0) -> pop, then stall_req=0.
5. Fill FIFO with 2 results while the pipeline writes continuously -> lat_ready=0; a third lat_valid is held off until after the first pop. Order is preserved.
6. RegWriteW=1, RdW=0 with FIFO head x9 -> x9 written that cycle. lat x0 -> never written; busy_vec unchanged.
